// File: rtl/demux_1x64b_to_40x64b_buf.sv
// Write-side scatter buffer: 64-bit handshake beats land in a registered 40 x 64-bit array,
// either at an explicit index or as an auto-incrementing burst that wraps past the last entry.
module demux_1x64b_to_40x64b_buf #(
    parameter int NUM_ENTRIES = 40,
    parameter int DATA_WIDTH  = 64,
    parameter int SEL_WIDTH   = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [SEL_WIDTH-1:0]              wr_select,
    input  logic                              burst_start,
    input  logic [SEL_WIDTH-1:0]              burst_base,
    input  logic [SEL_WIDTH-1:0]              burst_len,
    input  logic                              clear,
    output logic [NUM_ENTRIES*DATA_WIDTH-1:0] out,
    output logic [NUM_ENTRIES-1:0]            entry_valid,
    output logic                              all_valid,
    output logic                              burst_busy,
    output logic                              burst_done,
    output logic                              err_select
);

    localparam logic [SEL_WIDTH-1:0] NUM_SEL = SEL_WIDTH'(NUM_ENTRIES);
    localparam logic [SEL_WIDTH-1:0] LAST    = SEL_WIDTH'(NUM_ENTRIES - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    logic [SEL_WIDTH-1:0]    ptr;
    logic [SEL_WIDTH-1:0]    remaining;
    logic [DATA_WIDTH-1:0]   mem [NUM_ENTRIES];

    logic                    accept;
    logic                    wr_en;
    logic [SEL_WIDTH-1:0]    wr_idx;
    logic                    burst_ok;

    always_comb begin
        wr_ready = ~clear;
        accept   = wr_valid & wr_ready;
        burst_ok = (burst_len != '0) && (burst_len <= NUM_SEL) && (burst_base < NUM_SEL);
        wr_en    = 1'b0;
        wr_idx   = ptr;
        if (accept) begin
            if (state == BURST) begin
                wr_en  = 1'b1;
                wr_idx = ptr;
            end else if (wr_select < NUM_SEL) begin
                wr_en  = 1'b1;
                wr_idx = wr_select;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            remaining   <= '0;
            entry_valid <= '0;
            burst_done  <= 1'b0;
            err_select  <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
        end else if (clear) begin
            // Flush wins over everything, including a burst in flight (no done pulse).
            state       <= IDLE;
            ptr         <= '0;
            remaining   <= '0;
            entry_valid <= '0;
            burst_done  <= 1'b0;
            err_select  <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) mem[i] <= '0;
        end else begin
            burst_done <= 1'b0;
            if (wr_en) begin
                mem[wr_idx]         <= wr_data;
                entry_valid[wr_idx] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept && (wr_select >= NUM_SEL)) err_select <= 1'b1;
                    if (burst_start) begin
                        if (burst_ok) begin
                            ptr       <= burst_base;
                            remaining <= burst_len;
                            state     <= BURST;
                        end else begin
                            err_select <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (accept) begin
                        ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == SEL_WIDTH'(1)) begin
                            state      <= IDLE;
                            burst_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_flat
        assign out[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

    assign all_valid  = &entry_valid;
    assign burst_busy = (state == BURST);

endmodule

// File: tb/tb_demux_1x64b_to_40x64b_buf.sv
// Directed bench for the 40 x 64-bit scatter buffer: single writes, wrapping bursts,
// error flagging, synchronous flush and asynchronous reset.
module tb_demux_1x64b_to_40x64b_buf;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [63:0]   wr_data;
    logic [5:0]    wr_select;
    logic          burst_start;
    logic [5:0]    burst_base;
    logic [5:0]    burst_len;
    logic          clear;
    logic [2559:0] out;
    logic [39:0]   entry_valid;
    logic          all_valid;
    logic          burst_busy;
    logic          burst_done;
    logic          err_select;

    int total = 0;
    int bad   = 0;

    demux_1x64b_to_40x64b_buf dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_select(wr_select), .burst_start(burst_start),
        .burst_base(burst_base), .burst_len(burst_len), .clear(clear),
        .out(out), .entry_valid(entry_valid), .all_valid(all_valid),
        .burst_busy(burst_busy), .burst_done(burst_done), .err_select(err_select)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", out[63:0]); end
        total++; if (entry_valid !== 40'h0) begin bad++; $display("FAIL reset_ev got=%h exp=0", entry_valid); end
        total++; if ({all_valid, burst_busy, burst_done, err_select} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {all_valid, burst_busy, burst_done, err_select}); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    endtask

    task automatic test_single();
        logic [2559:0] exp_out;
        exp_out = '0;
        exp_out[383:320] = 64'hDEADBEEF_01234567;
        wr_valid = 1'b1; wr_select = 6'd5; wr_data = 64'hDEADBEEF_01234567;
        tick();
        wr_valid = 1'b0;
        total++; if (out[383:320] !== 64'hDEADBEEF_01234567) begin
            bad++; $display("FAIL single_data got=%h exp=deadbeef01234567", out[383:320]); end
        total++; if (out !== exp_out) begin bad++; $display("FAIL single_others got=%h exp=0 outside entry 5", out[319:0]); end
        total++; if (entry_valid !== 40'h20) begin bad++; $display("FAIL single_ev got=%h exp=20", entry_valid); end
    endtask

    task automatic test_burst_wrap();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0; done_cnt = 0;
        burst_start = 1'b1; burst_base = 6'd38; burst_len = 6'd4;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (burst_busy === 1'b1) busy_cnt++;
            if (burst_done === 1'b1) done_cnt++;
            wr_valid = 1'b1; wr_data = 64'(i + 1); wr_select = 6'd5;
            tick();
        end
        wr_valid = 1'b0;
        total++; if (burst_busy !== 1'b0) begin bad++; $display("FAIL burst_busy_end got=%b exp=0", burst_busy); end
        total++; if (burst_done !== 1'b1) begin bad++; $display("FAIL burst_done_pulse got=%b exp=1", burst_done); end
        done_cnt++;
        tick();
        if (burst_done === 1'b1) done_cnt++;
        total++; if (busy_cnt != 4) begin bad++; $display("FAIL burst_busy_cycles got=%0d exp=4", busy_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL burst_done_count got=%0d exp=1", done_cnt); end
        total++; if ({out[64*38 +: 64], out[64*39 +: 64], out[0 +: 64], out[64 +: 64]} !== {64'd1, 64'd2, 64'd3, 64'd4}) begin
            bad++; $display("FAIL burst_data got=%0d,%0d,%0d,%0d exp=1,2,3,4",
                            out[64*38 +: 64], out[64*39 +: 64], out[0 +: 64], out[64 +: 64]); end
        total++; if (out[383:320] !== 64'hDEADBEEF_01234567) begin bad++; $display("FAIL burst_keep5 got=%h", out[383:320]); end
        total++; if (entry_valid !== 40'hC0_0000_0023) begin bad++; $display("FAIL burst_ev got=%h exp=c000000023", entry_valid); end
    endtask

    task automatic test_fill_all();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 39) begin
                total++; if (all_valid !== 1'b0) begin bad++; $display("FAIL fill_early got=%b exp=0", all_valid); end
            end
            wr_valid = 1'b1; wr_select = 6'(i); wr_data = 64'(i);
            tick();
        end
        wr_valid = 1'b0;
        total++; if (all_valid !== 1'b1) begin bad++; $display("FAIL fill_all_valid got=%b exp=1", all_valid); end
        total++; if (out[2559:2496] !== 64'd39) begin bad++; $display("FAIL fill_top got=%0d exp=39", out[2559:2496]); end
        total++; if (out[64*17 +: 64] !== 64'd17) begin bad++; $display("FAIL fill_mid got=%0d exp=17", out[64*17 +: 64]); end
    endtask

    task automatic test_errors();
        logic [2559:0] exp_out;
        for (int i = 0; i < 40; i++) exp_out[64*i +: 64] = 64'(i);
        total++; if (err_select !== 1'b0) begin bad++; $display("FAIL err_initial got=%b exp=0", err_select); end
        wr_valid = 1'b1; wr_select = 6'd40; wr_data = 64'hFFFF;
        tick();
        wr_valid = 1'b0;
        total++; if (err_select !== 1'b1) begin bad++; $display("FAIL err_sel40 got=%b exp=1", err_select); end
        burst_start = 1'b1; burst_base = 6'd0; burst_len = 6'd0;
        tick();
        total++; if (burst_busy !== 1'b0) begin bad++; $display("FAIL err_len0_busy got=%b exp=0", burst_busy); end
        burst_base = 6'd45; burst_len = 6'd4;
        tick();
        burst_start = 1'b0;
        total++; if (burst_busy !== 1'b0) begin bad++; $display("FAIL err_base45_busy got=%b exp=0", burst_busy); end
        tick();
        total++; if (err_select !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_select); end
        total++; if (out !== exp_out) begin bad++; $display("FAIL err_no_write got=%h", out[2559:2496]); end
        total++; if (entry_valid !== {40{1'b1}}) begin bad++; $display("FAIL err_ev got=%h exp=ffffffffff", entry_valid); end
        clear = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL err_clear_ready got=%b exp=0", wr_ready); end
        tick();
        clear = 1'b0;
        total++; if (err_select !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", err_select); end
        total++; if ({entry_valid, all_valid} !== 41'h0) begin bad++; $display("FAIL err_clear_ev got=%h exp=0", entry_valid); end
    endtask

    task automatic test_clear_mid_burst();
        int done_cnt;
        done_cnt = 0;
        burst_start = 1'b1; burst_base = 6'd0; burst_len = 6'd10;
        tick();
        burst_start = 1'b0;
        wr_valid = 1'b1; wr_data = 64'd100; tick();
        wr_data = 64'd101; tick();
        total++; if (entry_valid !== 40'h3) begin bad++; $display("FAIL clr_two_beats got=%h exp=3", entry_valid); end
        clear = 1'b1;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", wr_ready); end
        tick();
        clear = 1'b0; wr_valid = 1'b0;
        total++; if (out !== '0) begin bad++; $display("FAIL clr_out got=%h exp=0", out[127:0]); end
        total++; if (entry_valid !== 40'h0) begin bad++; $display("FAIL clr_ev got=%h exp=0", entry_valid); end
        total++; if (burst_busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", burst_busy); end
        for (int i = 0; i < 12; i++) begin
            if (burst_done === 1'b1) done_cnt++;
            tick();
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL clr_done_count got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_async_reset();
        burst_start = 1'b1; burst_base = 6'd10; burst_len = 6'd5;
        tick();
        burst_start = 1'b0;
        wr_valid = 1'b1; wr_data = 64'd7; tick();
        total++; if ({burst_busy, entry_valid[10]} !== 2'b11) begin
            bad++; $display("FAIL arst_pre got=%b exp=11", {burst_busy, entry_valid[10]}); end
        #2 rst = 1'b0;
        #1;
        total++; if (out !== '0) begin bad++; $display("FAIL arst_out got=%h exp=0", out[64*10 +: 64]); end
        total++; if ({entry_valid, all_valid, burst_busy, burst_done, err_select} !== 44'h0) begin
            bad++; $display("FAIL arst_ctrl got=%h busy=%b exp=0", entry_valid, burst_busy); end
        #1 rst = 1'b1;
        wr_select = 6'd3; wr_data = 64'd55;
        tick();
        total++; if ({out[64*3 +: 64], entry_valid} !== {64'd55, 40'h8}) begin
            bad++; $display("FAIL arst_single got=%0d ev=%h exp=55 ev=8", out[64*3 +: 64], entry_valid); end
        total++; if (burst_busy !== 1'b0) begin bad++; $display("FAIL arst_idle got=%b exp=0", burst_busy); end
        wr_data = 64'd66;
        tick();
        wr_valid = 1'b0;
        total++; if ({out[64*3 +: 64], entry_valid} !== {64'd66, 40'h8}) begin
            bad++; $display("FAIL overwrite got=%0d ev=%h exp=66 ev=8", out[64*3 +: 64], entry_valid); end
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_select = '0;
        burst_start = 1'b0; burst_base = '0; burst_len = '0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        tick();
        test_single();
        test_burst_wrap();
        test_fill_all();
        test_errors();
        test_clear_mid_burst();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1x64b_to_40x64b_buf.md
Name: demux_1x64b_to_40x64b_buf

Overview:
Write-side counterpart of the 40-entry x 64-bit select read path. Accepts 64-bit words over a valid/ready handshake and scatters them into a registered 40 x 64-bit array, exposed as a flat 2560-bit bus. Entry i occupies bits [64*i+63 : 64*i]. Supports single-entry writes addressed by select and auto-incrementing bursts with wrap-around, and tracks per-entry valid bits.

Parameters:
NUM_ENTRIES, 40, number of 64-bit entries; fixed, not re-scaled.
DATA_WIDTH, 64, width of one entry.
SEL_WIDTH, 6, width of the entry index.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
wr_valid  input  1  write beat offered
wr_ready  output  1  block can accept a beat this cycle
wr_data  input  64  write data
wr_select  input  6  target entry for single writes; ignored during a burst
burst_start  input  1  start a burst; honoured only in IDLE
burst_base  input  6  first entry of the burst
burst_len  input  6  number of beats, legal range 1..40
clear  input  1  synchronous flush
out  output  2560  flat array contents, entry i at [64*i+63:64*i]
entry_valid  output  40  bit i set once entry i has been written since reset/clear
all_valid  output  1  all 40 entry_valid bits set
burst_busy  output  1  state is BURST
burst_done  output  1  one-cycle pulse after the last burst beat is accepted
err_select  output  1  sticky illegal index/length flag

Behaviour:
- Reset (rst low, asynchronous):
  - out = 0, entry_valid = 0, all_valid = 0, burst_busy = 0, burst_done = 0, err_select = 0.
  - State = IDLE, ptr = 0, remaining = 0.
- wr_ready = 1 in IDLE and BURST, and 0 in any cycle where clear = 1.
- A beat is accepted when wr_valid & wr_ready. The written entry and its entry_valid bit update at the next clock edge, so write-to-out latency is 1 cycle.
- IDLE, single write:
  - Accepted beat with wr_select < 40: out entry[wr_select] <= wr_data; entry_valid[wr_select] <= 1.
  - wr_select >= 40: beat is consumed, nothing is written, err_select <= 1.
- IDLE, burst_start:
  - burst_len in 1..40 and burst_base < 40: ptr <= burst_base, remaining <= burst_len, go to BURST.
  - Otherwise set err_select and stay in IDLE.
  - If burst_start and wr_valid are both high in the same IDLE cycle, the beat is a single write and the burst is also armed.
- BURST:
  - Each accepted beat writes entry[ptr] and sets entry_valid[ptr].
  - ptr <= (ptr == 39) ? 0 : ptr + 1; remaining <= remaining - 1.
  - When the beat is accepted with remaining == 1: go to IDLE, and burst_done = 1 for exactly the following cycle.
  - burst_start and wr_select are ignored while in BURST.
- all_valid = AND of entry_valid. It is combinational from the registered bits, so it rises in the same cycle the last bit sets.
- clear (highest priority):
  - At the next edge: out = 0, entry_valid = 0, state = IDLE, burst aborted with no burst_done pulse, err_select = 0.
  - A beat presented during a clear cycle is not accepted (wr_ready = 0).
- Rewriting an entry that is already valid overwrites its data; entry_valid stays 1.
- rst asserted mid-burst returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
- Reset, then single write wr_select=5, wr_data=64'hDEADBEEF_01234567 -> next cycle out[383:320] = that value, entry_valid = 40'h20, every other bit of out = 0.
- burst_base=38, burst_len=4, data 1,2,3,4 with back-to-back valid -> entries 38,39,0,1 hold 1,2,3,4. burst_busy is high for 4 cycles. burst_done pulses once, one cycle after the 4th beat.
- Single writes to all 40 entries with data = index -> all_valid rises in the cycle after the 40th write. out[2559:2496] = 39.
- wr_select=40, then burst_len=0, then burst_base=45 -> no entry changes, err_select = 1 and stays sticky. A later clear drops it to 0.
- clear asserted after 2 beats of a 10-beat burst with wr_valid held high -> wr_ready = 0 in the clear cycle, out = 0 and entry_valid = 0 afterwards, burst_busy = 0, burst_done never pulses.
- rst pulsed low between clock edges mid-burst -> all outputs reach reset values before the next edge. Beats after rst deasserts are treated as IDLE single writes.
